uart_mux_arbiter: RTL

Activity-driven controller for the shared 4-target UART crossbar. It watches the four target RX lines for start bits and grants the single host link to one requester at a time, using round-robin priority. It drives the 2-bit route select consumed by the UART mux and holds each grant until the link has been idle for a programmable number of clocks. A manual override lets the board pins force a fixed route.

---
 rtl/uart_mux_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_mux_arbiter.sv
// Round-robin owner of the shared host UART link across four targets, with pin-forced override.
// Define UART_ARB_TIMEOUT_EN to cut grants that exceed MAX_HOLD clocks.
module uart_mux_arbiter #(
    parameter int IDLE_CYCLES = 160,
    parameter int MAX_HOLD    = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tgt_rx,
    input  logic       host_rx,
    input  logic       force_en,
    input  logic [1:0] force_sel,
    output logic [1:0] sel,
    output logic       grant,
    output logic [3:0] pending,
    output logic       timeout_pulse
);
    localparam int IDLE_W = $clog2(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_FORCED
    } state_t;

    state_t            state;
    logic [3:0]        tgt_s1;
    logic [3:0]        tgt_s2;
    logic [3:0]        tgt_prev;
    logic              host_s1;
    logic              host_s2;
    logic              force_s1;
    logic              force_s2;
    logic [1:0]        last;
    logic [IDLE_W-1:0] idle_cnt;
    logic [3:0]        owned;
    logic [3:0]        new_req;
    logic [3:0]        set_pending;
    logic              link_quiet;
    logic              idle_done;
    logic              pick_valid;
    logic [1:0]        pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;

    assign hold_done = (hold_cnt == HOLD_LAST);
`else
    // MAX_HOLD only matters when the timeout is compiled in.
    assign timeout_pulse = (MAX_HOLD < 0);
`endif

    // The owner's own start bits are traffic, not new requests.
    assign owned       = (state != S_IDLE) ? (4'b0001 << sel) : 4'b0000;
    assign new_req     = tgt_prev & ~tgt_s2 & ~owned;
    assign set_pending = pending | new_req;
    assign link_quiet  = tgt_s2[sel] & host_s2;
    assign idle_done   = link_quiet && (idle_cnt == IDLE_LAST);

    // Nearest offset after last wins, so scan from the farthest offset inward.
    always_comb begin
        logic [1:0] cand;
        pick_valid = 1'b0;
        pick_idx   = last;
        cand       = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (pending[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_s1    <= 4'hF;
            tgt_s2    <= 4'hF;
            tgt_prev  <= 4'hF;
            host_s1   <= 1'b1;
            host_s2   <= 1'b1;
            force_s1  <= 1'b0;
            force_s2  <= 1'b0;
            state     <= S_IDLE;
            sel       <= 2'd0;
            grant     <= 1'b0;
            pending   <= 4'h0;
            last      <= 2'd3;
            idle_cnt  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            hold_cnt      <= '0;
            timeout_pulse <= 1'b0;
`endif
        end else begin
            tgt_s1   <= tgt_rx;
            tgt_s2   <= tgt_s1;
            tgt_prev <= tgt_s2;
            host_s1  <= host_rx;
            host_s2  <= host_s1;
            force_s1 <= force_en;
            force_s2 <= force_s1;
            pending  <= set_pending;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            if (force_s2) begin
                state    <= S_FORCED;
                sel      <= force_sel;
                grant    <= 1'b1;
                idle_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
                hold_cnt <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pick_valid) begin
                            state    <= S_GRANT;
                            sel      <= pick_idx;
                            last     <= pick_idx;
                            grant    <= 1'b1;
                            pending  <= set_pending & ~(4'b0001 << pick_idx);
                            idle_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
                            hold_cnt <= '0;
`endif
                        end
                    end
                    S_GRANT: begin
                        if (!link_quiet) begin
                            idle_cnt <= '0;
                        end else if (!idle_done) begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                        if (idle_done) begin
                            state <= S_IDLE;
                            grant <= 1'b0;
                        end
`ifdef UART_ARB_TIMEOUT_EN
                        // A hung or chatty target loses the link after MAX_HOLD clocks.
                        if (!hold_done) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end else begin
                            state         <= S_IDLE;
                            grant         <= 1'b0;
                            timeout_pulse <= 1'b1;
                        end
`endif
                    end
                    default: begin
                        state <= S_IDLE;
                        grant <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
